// File: rtl/on_off_link_transmitter.sv
// Upstream end of an on/off flow-controlled link: stages flits in a circular FIFO and pops them while on_q is set.
// Optional build macro ONOFF_STALL_TIMEOUT_EN adds a sticky stall_err_o once a HOLD stall reaches STALL_LIMIT cycles.
//
// state | meaning
// RUN   | on_q=1, or on_q=0 with nothing staged; pops whenever flits are present and on_q=1
// HOLD  | on_q=0 with flits pending; stall counter advances
module on_off_link_transmitter #(
  parameter int FLIT_W      = 32,
  parameter int STAGE_DEPTH = 4,
  parameter int STALL_CNT_W = 8,
  parameter int STALL_LIMIT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FLIT_W-1:0]      data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   on_off_i,
  output logic [FLIT_W-1:0]      data_o,
  output logic                   valid_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  output logic                   stall_err_o
);
  localparam int PTR_W = $clog2(STAGE_DEPTH);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t             state, state_next;
  logic               on_q;
  logic               empty, full;
  logic [PTR_W-1:0]   rptr, wptr, rptr_next, wptr_next;
  logic               pop_en, push_en;
  logic [FLIT_W-1:0]  mem [STAGE_DEPTH];

  if (STAGE_DEPTH < 2 || (STAGE_DEPTH & (STAGE_DEPTH - 1)) != 0 || STALL_LIMIT < 1) begin : g_bad_param
    $error("on_off_link_transmitter: STAGE_DEPTH must be a power of two >= 2 and STALL_LIMIT >= 1");
  end

  // Only the registered flag gates the pop, so on_off_i never reaches an output combinationally.
  assign pop_en    = on_q & ~empty;
  assign ready_o   = ~full | pop_en;
  assign push_en   = valid_i & ready_o;
  assign rptr_next = rptr + PTR_W'(1);
  assign wptr_next = wptr + PTR_W'(1);

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (!on_q && !empty) state_next = HOLD;
      HOLD:    if (on_q) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wptr] <= data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      on_q        <= 1'b1;
      rptr        <= '0;
      wptr        <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      valid_o     <= 1'b0;
      data_o      <= '0;
      stall_cnt_o <= '0;
    end else begin
      state <= state_next;
      on_q  <= on_off_i;
      if (push_en) wptr <= wptr_next;
      if (pop_en) begin
        rptr    <= rptr_next;
        data_o  <= mem[rptr];
        valid_o <= 1'b1;
      end else begin
        valid_o <= 1'b0;
      end
      // A simultaneous push and pop keeps the occupancy, so both flags stay put.
      if (push_en && !pop_en) begin
        empty <= 1'b0;
        full  <= (wptr_next == rptr);
      end else if (pop_en && !push_en) begin
        full  <= 1'b0;
        empty <= (rptr_next == wptr);
      end
      if (pop_en)
        stall_cnt_o <= '0;
      else if (state == HOLD && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
    end
  end

`ifdef ONOFF_STALL_TIMEOUT_EN
  logic stall_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_err <= 1'b0;
    else if (state == HOLD && stall_cnt_o == STALL_CNT_W'(STALL_LIMIT))
      stall_err <= 1'b1;
  end

  assign stall_err_o = stall_err;
`else
  assign stall_err_o = 1'b0;
`endif

endmodule

// File: doc/on_off_link_transmitter.md
Name: on_off_link_transmitter

Overview:
- Upstream end of the on/off flow-controlled link feeding a router input-port buffer.
- Stages flits from the switch traversal stage in a small circular FIFO and drives them onto the link one per cycle.
- Stops sending when the downstream on/off flag reads off and resumes when it reads on.
- Sits in the output port; its link outputs connect directly to the downstream input port's data/write inputs and its on_off_i to that port's on/off output.

Parameters:
STAGE_DEPTH, 4, staging FIFO entries (power of two, >=2)
STALL_CNT_W, 8, width of saturating stall counter
STALL_LIMIT, 64, off-cycle count that raises stall_err_o (optional feature only)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
data_i  input  flit_t  flit from switch traversal
valid_i  input  1  data_i valid this cycle
ready_o  output  1  transmitter accepts data_i this cycle
on_off_i  input  1  downstream on/off flag (1 = may send)
data_o  output  flit_t  flit on link
valid_o  output  1  link write strobe (drives downstream write_i)
stall_cnt_o  output  STALL_CNT_W  consecutive cycles held with pending flits
stall_err_o  output  1  stall timeout flag (0 when feature compiled out)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst low = reset), all state clears immediately on assertion.
- Reset values: FIFO empty, read/write pointers 0, on_q=1, valid_o=0, data_o=0, stall_cnt_o=0, stall_err_o=0, state=RUN; ready_o=1 combinationally after reset.
- on_off_i is registered into on_q every edge. on_q is the only flow-control term used, so on_off_i has no combinational path to any output.
- States:
  - RUN: on_q=1.
  - HOLD: on_q=0 and FIFO non-empty.
  - RUN -> HOLD when on_q falls with flits pending.
  - HOLD -> RUN when on_q rises.
  - on_q=0 with FIFO empty stays in RUN but pops nothing.
- pop_en = on_q & ~empty.
- On each edge, if pop_en: data_o <= head flit, valid_o <= 1, read pointer advances. Otherwise valid_o <= 0 and data_o holds its last value.
- Push occurs when valid_i & ready_o; data_i is written at the write pointer.
- ready_o = ~full | pop_en. A push into a full FIFO is allowed only in the same cycle as a pop.
- Pointers wrap from STAGE_DEPTH-1 to 0.
- Full/empty update rules:
  - full set when a push-only makes wptr_next == rptr.
  - empty set when a pop-only makes rptr_next == wptr.
  - simultaneous push+pop leaves both flags unchanged.
- Latency: a flit pushed at edge N appears with valid_o at edge N+1 at the earliest, when the FIFO was empty and on_q=1. on_off_i falling before edge M gives its last valid_o at edge M+1 (reaction of 2 edges). The downstream reserve of PIPELINE_DEPTH slots must cover this.
- Ordering is strict FIFO; no flit is dropped or duplicated.
- stall_cnt_o:
  - increments (saturating at all-ones) each cycle in HOLD.
  - clears to 0 on any pop.
  - holds otherwise.
- valid_i while ready_o=0: no push; the upstream holds data_i.
- Reset mid-transfer discards all staged flits; valid_o drops immediately (asynchronous).

Optional Feature:
- Macro: ONOFF_STALL_TIMEOUT_EN.
- Defined: stall_err_o is a sticky register, set when stall_cnt_o reaches STALL_LIMIT in HOLD. It is cleared only by reset.
- Undefined: stall_err_o is tied to 0 and no comparator is built. stall_cnt_o still functions.

Test Plan:
- Reset, on_off_i=1, push flits A,B,C on consecutive cycles -> valid_o high on edges 2,3,4 with data_o A,B,C; ready_o stays 1.
- on_off_i=0 held, push 4 flits -> ready_o=0 after the 4th; 5th valid_i not accepted; valid_o=0 throughout; stall_cnt_o counts 1,2,3...
- From full with on_off_i=0, raise on_off_i -> on_q high next edge; valid_o high on the following edge; ready_o=1 the same cycle pop_en=1; a push in that cycle is accepted with order preserved.
- Continuous traffic, drop on_off_i for 1 cycle at cycle 10 -> exactly one valid_o bubble two edges later; stream order intact across pointer wrap (>8 flits).
- ONOFF_STALL_TIMEOUT_EN defined, STALL_LIMIT=5, hold off with 1 flit pending -> stall_err_o=1 after 5 HOLD cycles and stays 1 after resume; compiled out -> stays 0.
- Assert rst low with 3 flits staged -> valid_o=0 and ready_o=1 immediately; after release, no stale flit is emitted.
